// File: rtl/i2d_dual_slope.sv
// rtl/i2d_dual_slope.sv - dual-slope integrating current-to-digital converter, real-valued model
// Integrates IIN for N_INT cycles, then counts reference de-integration steps to the zero crossing.
module i2d_dual_slope #(
  parameter int  NBITS = 10,
  parameter int  N_INT = 256,
  parameter real I_REF = 10.0e-3,
  parameter real T_CLK = 10.0e-9,
  parameter real C_INT = 100.0e-9,
  parameter real V_SAT = 5.0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  real              IIN,
  output real              VINT,
  output logic [NBITS-1:0] DOUT,
  output logic             VALID,
  output logic             BUSY,
  output logic             OVR
);

  localparam real         DV_REF   = I_REF * T_CLK / C_INT;
  localparam real         V_THRESH = 0.5 * DV_REF;
  localparam logic [31:0] CNT_LAST = 32'(N_INT - 1);
  localparam logic [31:0] CNT_MAX  = 32'((2 ** NBITS) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INTEGRATE,
    S_DEINTEGRATE
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] cnt_inc;
  real         dv_in;
  real         v_sum;
  real         v_int_next;
  real         v_dei_next;
  logic        sat;

  always_comb begin
    dv_in      = IIN * T_CLK / C_INT;
    v_sum      = VINT + dv_in;
    v_int_next = v_sum;
    sat        = 1'b0;
    if (v_sum > V_SAT) begin
      v_int_next = V_SAT;
      sat        = 1'b1;
    end else if (v_sum < -V_SAT) begin
      v_int_next = -V_SAT;
      sat        = 1'b1;
    end
    v_dei_next = VINT - DV_REF;
    cnt_inc    = cnt + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      VINT  <= 0.0;
      DOUT  <= '0;
      VALID <= 1'b0;
      BUSY  <= 1'b0;
      OVR   <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            OVR   <= 1'b0;
            VINT  <= 0.0;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= S_INTEGRATE;
          end
        end
        S_INTEGRATE: begin
          VINT <= v_int_next;
          cnt  <= cnt_inc;
          if (sat) OVR <= 1'b1;
          if (cnt == CNT_LAST) begin
            // Nothing meaningful to de-integrate: zero or negative input gives a zero code
            if (v_int_next <= V_THRESH) begin
              DOUT  <= '0;
              VALID <= 1'b1;
              BUSY  <= 1'b0;
              state <= S_IDLE;
            end else begin
              cnt   <= '0;
              state <= S_DEINTEGRATE;
            end
          end
        end
        S_DEINTEGRATE: begin
          VINT <= v_dei_next;
          cnt  <= cnt_inc;
          // Half-step threshold rounds to nearest and hides floating-point residue
          if (v_dei_next <= V_THRESH) begin
            DOUT  <= cnt_inc[NBITS-1:0];
            VALID <= 1'b1;
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end else if (cnt_inc == CNT_MAX) begin
            DOUT  <= '1;
            OVR   <= 1'b1;
            VALID <= 1'b1;
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2d_dual_slope.sv
// tb/tb_i2d_dual_slope.sv - directed-vector bench for i2d_dual_slope
module tb_i2d_dual_slope;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  real        iin = 0.0;
  logic       start_a, start_b;
  real        vint_a, vint_b;
  logic [9:0] dout_a, dout_b;
  logic       valid_a, valid_b, busy_a, busy_b, ovr_a, ovr_b;
  logic [9:0] m_dout;
  logic       m_valid, m_busy, m_ovr;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign m_dout  = sel ? dout_b  : dout_a;
  assign m_valid = sel ? valid_b : valid_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_ovr   = sel ? ovr_b   : ovr_a;

  i2d_dual_slope u_dut (
    .CLK(clk), .RST(rst), .START(start_a), .IIN(iin), .VINT(vint_a),
    .DOUT(dout_a), .VALID(valid_a), .BUSY(busy_a), .OVR(ovr_a)
  );

  i2d_dual_slope #(.N_INT(2048)) u_dut_long (
    .CLK(clk), .RST(rst), .START(start_b), .IIN(iin), .VINT(vint_b),
    .DOUT(dout_b), .VALID(valid_b), .BUSY(busy_b), .OVR(ovr_b)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic launch(input real i);
    iin   = i;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int restart_at, output int lat, output int nv, output real peak);
    lat  = 0;
    nv   = 0;
    peak = 0.0;
    while (lat < 4000 && nv == 0) begin
      @(posedge clk);
      #1;
      lat++;
      if (vint_a > peak) peak = vint_a;
      if (m_valid) nv++;
      start = (lat == restart_at);
    end
    start = 1'b0;
  endtask

  task automatic watch(input int n, output int nv);
    nv = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (m_valid) nv++;
    end
  endtask

  int  lat, nv, nv2;
  real peak;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_ovr", ovr_a, 0);
    check("rst_vint_uv", $rtoi(vint_a * 1.0e6), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    launch(5.0e-3);
    check("mid_busy_e0", busy_a, 1);
    wait_valid(-1, lat, nv, peak);
    check("mid_dout", m_dout, 128);
    check("mid_ovr", m_ovr, 0);
    check("mid_lat", lat, 384);
    check("mid_peak_uv", $rtoi(peak * 1.0e6 + 0.5), 128000);
    check("mid_busy_end", m_busy, 0);
    watch(1, nv2);
    check("mid_valid_pulse", nv2, 0);

    launch(0.0);
    wait_valid(-1, lat, nv, peak);
    check("zero_dout", m_dout, 0);
    check("zero_lat", lat, 256);
    launch(-2.0e-3);
    wait_valid(-1, lat, nv, peak);
    check("neg_dout", m_dout, 0);
    check("neg_lat", lat, 256);
    check("neg_ovr", m_ovr, 0);

    launch(10.0e-3);
    wait_valid(-1, lat, nv, peak);
    check("fs_dout", m_dout, 256);
    check("fs_lat", lat, 512);
    check("fs_ovr", m_ovr, 0);

    launch(1.0);
    wait_valid(-1, lat, nv, peak);
    check("sat_dout", m_dout, 1023);
    check("sat_ovr", m_ovr, 1);
    check("sat_lat", lat, 256 + 1023);
    watch(20, nv2);
    check("sat_ovr_held", m_ovr, 1);

    sel = 1'b1;
    launch(10.0e-3);
    wait_valid(-1, lat, nv, peak);
    check("long_dout", m_dout, 1023);
    check("long_ovr", m_ovr, 1);
    check("long_lat", lat, 2048 + 1023);
    sel = 1'b0;

    launch(5.0e-3);
    check("busy_ovr_cleared", ovr_a, 0);
    wait_valid(50, lat, nv, peak);
    check("busy_dout", m_dout, 128);
    check("busy_lat", lat, 384);
    watch(400, nv2);
    check("busy_extra_valid", nv2, 0);
    check("busy_idle", m_busy, 0);

    launch(5.0e-3);
    watch(300, nv2);
    check("rstmid_busy_before", busy_a, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstmid_dout", dout_a, 0);
    check("rstmid_valid", valid_a, 0);
    check("rstmid_busy", busy_a, 0);
    check("rstmid_ovr", ovr_a, 0);
    check("rstmid_vint_uv", $rtoi(vint_a * 1.0e6), 0);
    watch(200, nv2);
    check("rstmid_no_valid", nv2, 0);
    launch(5.0e-3);
    wait_valid(-1, lat, nv, peak);
    check("rstmid_after_dout", m_dout, 128);
    check("rstmid_after_lat", lat, 384);

    launch(3.0e-3);
    wait_valid(-1, lat, nv, peak);
    check("b2b1_dout", m_dout, 77);
    check("b2b1_lat", lat, 333);
    launch(7.5e-3);
    check("b2b2_busy_nogap", busy_a, 1);
    check("b2b2_valid_low", valid_a, 0);
    wait_valid(-1, lat, nv, peak);
    check("b2b2_dout", m_dout, 192);
    check("b2b2_lat", lat, 448);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/i2d_dual_slope.md
# i2d_dual_slope

Clocked dual-slope integrating converter that consumes the current produced by the voltage-to-current stage and turns it into a digital code. An input current is integrated onto a modelled capacitor for a fixed number of cycles, then de-integrated with a reference current while a counter runs. The count at the zero crossing is the result. It sits directly downstream of the V→I converter in the RNM signal chain and uses `cds_rnm_pkg` real-valued nets.

## Interface

Parameters:

- `NBITS`, 10: output code width. Maximum count is 2^NBITS−1.
- `N_INT`, 256: integration length in clock cycles, ≥1.
- `I_REF`, 10.0e-3: de-integration reference current, in A, >0.
- `T_CLK`, 10.0e-9: clock period used for charge computation, in s.
- `C_INT`, 100.0e-9: integration capacitor, in F.
- `V_SAT`, 5.0: integrator saturation magnitude, in V.

Ports:

- Clock and reset: one clock; reset is synchronous and active-high.
  - `CLK`  in  1  clock.
  - `RST`  in  1  synchronous, active-high reset.
- `START`  in  1  conversion request; sampled only in IDLE.
- `IIN`  in  wreal1driver  input current in A, driven by the V→I stage.
- `VINT`  out  wreal1driver  integrator voltage in V, for observation.
- `DOUT`  out  NBITS  conversion result; holds until the next result.
- `VALID`  out  1  one-cycle pulse, DOUT updated.
- `BUSY`  out  1  high in INTEGRATE and DEINTEGRATE.
- `OVR`  out  1  overrange flag; held until the next accepted START.

## Operation

Derived quantities:

- `dV_in` = IIN·T_CLK/C_INT, sampled at each edge.
- `dV_ref` = I_REF·T_CLK/C_INT.

FSM states: IDLE, INTEGRATE, DEINTEGRATE. All updates occur on rising edges of CLK.

- **IDLE**
  - If START=1: OVR←0, VINT←0.0, cnt←0, go to INTEGRATE.
  - Otherwise hold all outputs.
- **INTEGRATE**
  - Each edge: VINT←clamp(VINT+dV_in, −V_SAT, +V_SAT) and cnt++.
  - If the clamp engages, OVR←1.
  - On the N_INT-th integration edge:
    - If the resulting VINT ≤ 0.5·dV_ref: DOUT←0, VALID←1, go to IDLE.
    - Otherwise: cnt←0, go to DEINTEGRATE.
- **DEINTEGRATE**
  - Each edge: VINT←VINT−dV_ref and cnt←cnt+1.
  - If the new VINT ≤ 0.5·dV_ref: DOUT←new cnt, VALID←1, go to IDLE.
  - Else if the new cnt = 2^NBITS−1: DOUT←all ones, OVR←1, VALID←1, go to IDLE.
- START is ignored while BUSY=1. It is not queued.
- Nominal result is DOUT = round(IIN·N_INT/I_REF) for non-negative IIN.
  - The 0.5·dV_ref threshold provides round-to-nearest and absorbs floating-point error.
- Negative or zero IIN gives DOUT=0.
- IIN is not clamped here; only VINT saturates.
- All arithmetic is real. cnt is an integer wide enough to hold max(N_INT, 2^NBITS).

## Timing

- Reset values, applied on the first edge with RST=1:
  - DOUT=0, VALID=0, BUSY=0, OVR=0, VINT=0.0, state IDLE, cnt=0.
  - RST has priority over everything, including mid-conversion. The partial conversion is discarded and no VALID is generated.
- Edge e0 is the edge that accepts START.
  - BUSY=1 after e0.
  - Integration occurs on edges e1..eN, with N = N_INT.
  - De-integration occurs on edges eN+1..eN+K.
  - VALID=1 for exactly one cycle after edge eN+K, or after eN if there is no de-integration.
  - BUSY falls on the same edge that raises VALID.
- Latency from START to VALID is N_INT+K edges, where K = result (K=0 for a zero result).
- START may be asserted in the cycle VALID is high. It is accepted on the next edge, since the FSM is in IDLE.
- VALID never asserts twice per conversion.

## Test plan

1. **Mid-scale conversion.** Defaults, IIN=5.0e-3, START pulse.
   - DOUT=128, OVR=0.
   - VALID exactly 384 edges after e0.
   - VINT peaks at 0.128 V.
2. **Zero and negative input.** IIN=0.0, then IIN=−2.0e-3.
   - DOUT=0, VALID 256 edges after e0.
   - No DEINTEGRATE entered.
3. **Full scale and overrange.** IIN=10.0e-3 → DOUT=256.
   - Override N_INT=2048 with IIN=10.0e-3 → DOUT=1023, OVR=1.
   - VALID 2048+1023 edges after e0.
4. **START while busy.** Pulse START again 50 edges into INTEGRATE.
   - It is ignored: one VALID only, DOUT matches the single-conversion value.
5. **Reset mid-operation.** Assert RST during DEINTEGRATE.
   - All outputs at reset values after the next edge, no VALID.
   - A new START then converts correctly.
6. **Back-to-back conversions.** Assert START in the VALID cycle with IIN changed 3.0e-3 → 7.5e-3.
   - DOUT=77, then DOUT=192.
   - Second conversion begins with no idle gap.
